// File: rtl/inst_fetch_pkg.sv
// Shared types for the instruction fetch unit: PC select encoding and buffer entry payload.
package inst_fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        PC_PC4 = 1'b0,
        PC_ALU = 1'b1
    } PCSel_t;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: issues word requests, tracks up to 2 in flight, buffers 2 responses for decode.
// Optional FETCH_MISALIGN_CHK_EN flags redirects whose target is not word-aligned.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  PCSel_t          pc_sel,
    input  logic [XLEN-1:0] alu_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] inst_pc4,
    output logic            fetch_misalign
);

    localparam logic [XLEN-1:0] WORD_MASK  = ~XLEN'(3);
    localparam logic [XLEN-1:0] RESET_PC_A = RESET_PC & WORD_MASK;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]      out_cnt_q, out_cnt_d;
    logic [1:0]      disc_cnt_q, disc_cnt_d;
    logic [XLEN-1:0] opc0_q, opc0_d, opc1_q, opc1_d;
    fetch_entry_t    head_q, head_d, tail_q, tail_d;
    logic            head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
    logic [XLEN-1:0] head_pc4_q, head_pc4_d;

    logic            redirect, pop, grant, rsp, push;
    logic [2:0]      occupancy;
    logic [1:0]      out_after_rsp;

    // Request gating: buffered + in-flight (including discards) after this cycle's pop must leave room
    assign redirect  = (pc_sel == PC_ALU);
    assign pop       = head_vld_q && inst_ready;
    assign occupancy = 3'(head_vld_q) + 3'(tail_vld_q) + 3'(out_cnt_q) - 3'(pop);
    assign imem_req  = rst_n && !redirect && (occupancy < 3'd2);
    assign grant     = imem_req && imem_gnt;
    assign rsp       = imem_rvalid && (out_cnt_q != 2'd0);
    assign push      = rsp && (disc_cnt_q == 2'd0) && !redirect;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        out_cnt_d     = out_cnt_q;
        disc_cnt_d    = disc_cnt_q;
        opc0_d        = opc0_q;
        opc1_d        = opc1_q;
        head_d        = head_q;
        tail_d        = tail_q;
        head_vld_d    = head_vld_q;
        tail_vld_d    = tail_vld_q;
        out_after_rsp = out_cnt_q - 2'(rsp);

        // In-flight request PCs, oldest in opc0
        if (rsp) begin
            opc0_d = opc1_q;
        end
        if (grant) begin
            if (out_after_rsp == 2'd0) begin
                opc0_d = fetch_pc_q;
            end else begin
                opc1_d = fetch_pc_q;
            end
        end
        out_cnt_d = out_after_rsp + 2'(grant);

        if (redirect) begin
            fetch_pc_d = alu_target & WORD_MASK;
        end else if (grant) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end

        // Every request still in flight at a redirect belongs to the old stream
        if (redirect) begin
            disc_cnt_d = out_cnt_d;
        end else if (rsp && (disc_cnt_q != 2'd0)) begin
            disc_cnt_d = disc_cnt_q - 2'd1;
        end

        if (pop) begin
            head_d     = tail_q;
            head_vld_d = tail_vld_q;
            tail_vld_d = 1'b0;
        end
        if (push) begin
            if (!head_vld_d) begin
                head_d     = '{inst: imem_rdata, pc: opc0_q};
                head_vld_d = 1'b1;
            end else begin
                tail_d     = '{inst: imem_rdata, pc: opc0_q};
                tail_vld_d = 1'b1;
            end
        end
        if (redirect) begin
            head_vld_d = 1'b0;
            tail_vld_d = 1'b0;
        end
        head_pc4_d = head_d.pc + XLEN'(4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC_A;
            out_cnt_q  <= 2'd0;
            disc_cnt_q <= 2'd0;
            opc0_q     <= '0;
            opc1_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
            head_pc4_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_cnt_q  <= out_cnt_d;
            disc_cnt_q <= disc_cnt_d;
            opc0_q     <= opc0_d;
            opc1_q     <= opc1_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
            head_pc4_q <= head_pc4_d;
        end
    end

    assign imem_addr  = fetch_pc_q;
    assign inst_valid = head_vld_q;
    assign inst       = head_q.inst;
    assign inst_pc    = head_q.pc;
    assign inst_pc4   = head_pc4_q;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q, misalign_d;

    assign misalign_d = redirect && (alu_target[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign fetch_misalign = misalign_q;
`else
    assign fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with an in-order instruction memory model (rdata = ~addr).
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    PCSel_t      pc_sel = PC_PC4;
    logic [31:0] alu_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst, inst_pc, inst_pc4;
    logic        fetch_misalign;

    logic        rsp_en = 1'b1;
    logic [31:0] mem_q[$];
    logic [31:0] rsp_addr;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef FETCH_MISALIGN_CHK_EN
    localparam logic [31:0] MIS_EXP = 32'd1;
`else
    localparam logic [31:0] MIS_EXP = 32'd0;
`endif

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_sel         (pc_sel),
        .alu_target     (alu_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_pc4       (inst_pc4),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clk = ~clk;

    // Memory model: a grant is answered at the earliest one cycle later, in order, when rsp_en
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q.delete();
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end else begin
            if (imem_req && imem_gnt) mem_q.push_back(imem_addr);
            if (rsp_en && mem_q.size() > 0) begin
                rsp_addr = mem_q.pop_front();
                imem_rvalid <= 1'b1;
                imem_rdata  <= ~rsp_addr;
            end else begin
                imem_rvalid <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        pc_sel     = PC_PC4;
        alu_target = '0;
        imem_gnt   = 1'b1;
        rsp_en     = 1'b1;
        inst_ready = 1'b1;
        #1;
        check("rst_req",      32'(imem_req),       32'd0);
        check("rst_valid",    32'(inst_valid),     32'd0);
        check("rst_addr",     imem_addr,           32'h0);
        check("rst_inst",     inst,                32'h0);
        check("rst_pc",       inst_pc,             32'h0);
        check("rst_pc4",      inst_pc4,            32'h0);
        check("rst_misalign", 32'(fetch_misalign), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic wait_inst(input string tag, input int budget);
        int i;
        i = 0;
        while (!inst_valid && i < budget) begin
            step();
            i++;
        end
        check(tag, 32'(inst_valid), 32'd1);
    endtask

    initial begin
        #1;
        // Streaming from reset at one instruction per cycle
        apply_reset();
        check("s_req0",  32'(imem_req), 32'd1);
        check("s_addr0", imem_addr, 32'h0);
        step();
        check("s_addr1",  imem_addr, 32'h4);
        check("s_valid1", 32'(inst_valid), 32'd0);
        step();
        check("s_addr2",  imem_addr, 32'h8);
        check("s_valid2", 32'(inst_valid), 32'd1);
        check("s_pc2",    inst_pc, 32'h0);
        check("s_inst2",  inst, 32'hFFFF_FFFF);
        check("s_pc4_2",  inst_pc4, 32'h4);
        step();
        check("s_pc3",   inst_pc, 32'h4);
        check("s_pc4_3", inst_pc4, 32'h8);
        step();
        check("s_pc4", inst_pc, 32'h8);

        // Decode stall: buffer fills, requests stop, head holds
        inst_ready = 1'b0;
        #1;
        check("st_req_first", 32'(imem_req), 32'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("st_pc",    inst_pc, 32'h8);
            check("st_inst",  inst, ~32'h8);
            check("st_valid", 32'(inst_valid), 32'd1);
            check("st_req",   32'(imem_req), 32'd0);
        end
        inst_ready = 1'b1;
        #1;
        check("st_resume_req",  32'(imem_req), 32'd1);
        check("st_resume_addr", imem_addr, 32'h10);
        step();
        check("st_resume_pc0", inst_pc, 32'hC);
        step();
        check("st_resume_pc1", inst_pc, 32'h10);

        // Redirect with two requests in flight: both responses must be dropped
        apply_reset();
        rsp_en = 1'b0;
        check("rd_req0", 32'(imem_req), 32'd1);
        step();
        check("rd_addr1", imem_addr, 32'h4);
        step();
        check("rd_req_full", 32'(imem_req), 32'd0);
        pc_sel     = PC_ALU;
        alu_target = 32'h100;
        #1;
        check("rd_req_redirect", 32'(imem_req), 32'd0);
        step();
        pc_sel = PC_PC4;
        rsp_en = 1'b1;
        check("rd_flush_valid", 32'(inst_valid), 32'd0);
        check("rd_addr_tgt",    imem_addr, 32'h100);
        wait_inst("rd_wait", 12);
        check("rd_first_pc",   inst_pc, 32'h100);
        check("rd_first_inst", inst, ~32'h100);

        // Grant stall at 0x8
        apply_reset();
        step();
        step();
        check("gs_addr", imem_addr, 32'h8);
        imem_gnt = 1'b0;
        #1;
        check("gs_req", 32'(imem_req), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("gs_hold_addr", imem_addr, 32'h8);
            check("gs_hold_req",  32'(imem_req), 32'd1);
        end
        imem_gnt = 1'b1;
        step();
        check("gs_addr_next", imem_addr, 32'hC);
        step();
        check("gs_pc", inst_pc, 32'h8);

        // Address wrap from 0xFFFF_FFFC
        apply_reset();
        pc_sel     = PC_ALU;
        alu_target = 32'hFFFF_FFFC;
        #1;
        check("wr_req_redirect", 32'(imem_req), 32'd0);
        step();
        pc_sel = PC_PC4;
        #1;
        check("wr_req",  32'(imem_req), 32'd1);
        check("wr_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wr_addr_next", imem_addr, 32'h0);
        step();
        check("wr_valid", 32'(inst_valid), 32'd1);
        check("wr_pc",    inst_pc, 32'hFFFF_FFFC);
        check("wr_pc4",   inst_pc4, 32'h0);
        check("wr_inst",  inst, 32'h3);

        // Misaligned redirect target
        pc_sel     = PC_ALU;
        alu_target = 32'h102;
        #1;
        check("ma_before", 32'(fetch_misalign), 32'd0);
        step();
        pc_sel = PC_PC4;
        check("ma_pulse", 32'(fetch_misalign), MIS_EXP);
        check("ma_addr",  imem_addr, 32'h100);
        check("ma_flush", 32'(inst_valid), 32'd0);
        step();
        check("ma_clear", 32'(fetch_misalign), 32'd0);
        wait_inst("ma_wait", 12);
        check("ma_pc", inst_pc, 32'h100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; bits [1:0] are treated as zero.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port pc_sel, input, 1, PCSel_t: PC_ALU requests a redirect this cycle; PC_PC4 means no redirect.
REQ-005 SHALL have port alu_target, input, 32: redirect target, valid when pc_sel==PC_ALU.
REQ-006 SHALL have port imem_req, output, 1: fetch request to instruction memory.
REQ-007 SHALL have port imem_addr, output, 32: request address, word-aligned.
REQ-008 SHALL have port imem_gnt, input, 1: request accepted when imem_req && imem_gnt.
REQ-009 SHALL have port imem_rvalid, input, 1: response valid; responses return in request order, at least 1 cycle after grant.
REQ-010 SHALL have port imem_rdata, input, 32: instruction word, valid with imem_rvalid.
REQ-011 SHALL have port inst_valid, output, 1: head instruction available to decode.
REQ-012 SHALL have port inst_ready, input, 1: decode consumes when inst_valid && inst_ready.
REQ-013 SHALL have ports inst, inst_pc and inst_pc4, output, 32 each: head instruction, its address, and its address + 4.
REQ-014 SHALL have port fetch_misalign, output, 1: misaligned-redirect flag (see Configuration).

Function
REQ-015 SHALL hold a 2-entry in-order buffer of {instruction, PC}, plus a fetch_pc register and an outstanding-request count of 0..2.
REQ-016 SHALL drive imem_req=1 when (buffered + outstanding - pop) < 2 and no redirect occurs this cycle, where pop = inst_valid && inst_ready.
REQ-017 SHALL hold imem_addr = fetch_pc stable while imem_req=1 and no grant; on grant, fetch_pc <= fetch_pc + 4, wrapping modulo 2^32.
REQ-018 SHALL write imem_rdata together with its request PC into the buffer tail when imem_rvalid=1 and the discard count is 0.
REQ-019 SHALL register buffer outputs: inst_valid rises the cycle after imem_rvalid; no combinational path from imem_rdata to inst.
REQ-020 SHALL keep inst, inst_pc and inst_pc4 stable while inst_valid=1 && inst_ready=0.
REQ-021 SHALL sustain 1 instruction per cycle with zero-wait grant, 1-cycle response latency and inst_ready held high.
REQ-022 SHALL take the following actions on redirect (pc_sel==PC_ALU), on the same edge:
- flush the buffer, so inst_valid=0 the next cycle;
- fetch_pc <= {alu_target[31:2], 2'b00};
- discard count <= outstanding after this cycle's grant/response accounting;
- force imem_req=0 in the redirect cycle (an ungranted request is withdrawn).
REQ-023 SHALL drop responses while the discard count is non-zero, decrementing the count per dropped response; a response arriving in the redirect cycle itself is dropped.
REQ-024 SHALL issue requests to the new target while discards are pending, subject to REQ-016 with discarded requests counted as outstanding.
REQ-025 SHALL ignore inst_ready when inst_valid=0; a pop and a push in the same cycle are both honoured.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously set:
- fetch_pc=RESET_PC;
- buffer empty, outstanding=0, discard=0;
- imem_req=0, inst_valid=0, inst=inst_pc=inst_pc4=0, fetch_pc-derived imem_addr=RESET_PC;
- fetch_misalign=0.
REQ-027 SHALL assert imem_req in the first cycle after rst_n deasserts; reset mid-operation drops all buffered and in-flight state, and late responses are ignored (outstanding=0).

Configuration
REQ-028 SHALL, when FETCH_MISALIGN_CHK_EN is defined, pulse fetch_misalign=1 for one cycle (registered, the cycle after the redirect) when a redirect has alu_target[1:0]!=0; the redirect still proceeds per REQ-022.
REQ-029 SHALL, when FETCH_MISALIGN_CHK_EN is undefined, tie fetch_misalign to 0 and include no check logic.

Verification
REQ-030 SHALL verify reset release, RESET_PC=0x0, gnt=1, 1-cycle response, ready=1 -> imem_addr 0x0,0x4,0x8 on consecutive cycles; inst_pc 0x0,0x4,... one per cycle; inst_pc4=inst_pc+4.
REQ-031 SHALL verify inst_ready=0 for 5 cycles -> at most 2 buffered plus 0 outstanding, imem_req=0, head inst/inst_pc held; resumes in order.
REQ-032 SHALL verify redirect to 0x100 with 2 outstanding requests -> both responses dropped, next inst_pc=0x100, no stale instruction seen.
REQ-033 SHALL verify imem_gnt=0 for 3 cycles at addr 0x8 -> imem_addr stays 0x8, no fetch_pc advance.
REQ-034 SHALL verify fetch_pc=0xFFFF_FFFC granted -> next request addr 0x0.
REQ-035 SHALL verify, with FETCH_MISALIGN_CHK_EN, redirect to 0x102 -> fetch_misalign=1 for one cycle, next fetch 0x100; without the macro -> fetch_misalign stays 0.
